// File: rtl/gpr_scoreboard.sv
// Integer register scoreboard: pending-write busy bits and producer itags for x1-x31.
// Optional same-cycle release bypass on lookups: define PRV664_SCOREBOARD_BYPASS_EN.
module gpr_scoreboard #(
    parameter int REGNUM = 32,
    parameter int TAGW   = 8
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic                      upd_write_i,
    input  logic [$clog2(REGNUM)-1:0] upd_rdindex_i,
    input  logic [TAGW-1:0]           upd_itag_i,
    input  logic                      rel_valid_i,
    input  logic [$clog2(REGNUM)-1:0] rel_rdindex_i,
    input  logic [TAGW-1:0]           rel_itag_i,
    input  logic                      flush_i,
    input  logic [$clog2(REGNUM)-1:0] rs1_index_i,
    input  logic [$clog2(REGNUM)-1:0] rs2_index_i,
    input  logic [$clog2(REGNUM)-1:0] rd_index_i,
    output logic                      rs1_busy_o,
    output logic                      rs2_busy_o,
    output logic                      rd_busy_o,
    output logic [TAGW-1:0]           rs1_itag_o,
    output logic [TAGW-1:0]           rs2_itag_o,
    output logic [$clog2(REGNUM):0]   busy_cnt_o,
    output logic                      idle_o
);

    localparam int IW = $clog2(REGNUM);

    logic [REGNUM-1:0] r_busy;
    logic [TAGW-1:0]   r_itag [REGNUM];
    logic [IW:0]       r_cnt;

    logic w_upd_en;
    logic w_same_reg;
    logic w_rel_ok;
    logic w_rel_eff;
    logic w_inc;
    logic w_dec;
    logic w_byp;

    assign w_upd_en   = upd_write_i && (upd_rdindex_i != '0);
    assign w_same_reg = w_upd_en && (upd_rdindex_i == rel_rdindex_i);

    // A mismatching tag means a newer producer owns the entry.
    assign w_rel_ok  = rel_valid_i
                     && r_busy[rel_rdindex_i]
                     && (r_itag[rel_rdindex_i] == rel_itag_i);
    assign w_rel_eff = w_rel_ok && !w_same_reg;

    assign w_inc = w_upd_en && !r_busy[upd_rdindex_i];
    assign w_dec = w_rel_eff;

`ifdef PRV664_SCOREBOARD_BYPASS_EN
    assign w_byp = w_rel_eff && !flush_i && !srst_i;
`else
    assign w_byp = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_busy <= '0;
            r_cnt  <= '0;
            for (int i = 0; i < REGNUM; i++) begin
                r_itag[i] <= '0;
            end
        end else if (flush_i) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_rel_eff) begin
                r_busy[rel_rdindex_i] <= 1'b0;
            end
            if (w_upd_en) begin
                r_busy[upd_rdindex_i] <= 1'b1;
                r_itag[upd_rdindex_i] <= upd_itag_i;
            end
            r_cnt <= r_cnt + (IW+1)'(w_inc) - (IW+1)'(w_dec);
        end
    end

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_rd_hit;

    assign w_rs1_hit = w_byp && (rs1_index_i == rel_rdindex_i);
    assign w_rs2_hit = w_byp && (rs2_index_i == rel_rdindex_i);
    assign w_rd_hit  = w_byp && (rd_index_i  == rel_rdindex_i);

    assign rs1_busy_o = r_busy[rs1_index_i] && !w_rs1_hit;
    assign rs2_busy_o = r_busy[rs2_index_i] && !w_rs2_hit;
    assign rd_busy_o  = r_busy[rd_index_i]  && !w_rd_hit;

    assign rs1_itag_o = rs1_busy_o ? r_itag[rs1_index_i] : '0;
    assign rs2_itag_o = rs2_busy_o ? r_itag[rs2_index_i] : '0;

    assign busy_cnt_o = r_cnt;
    assign idle_o     = (r_cnt == '0);

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Bench for gpr_scoreboard: directed scenarios then random traffic
// against an array-based model of the pending-register set.
module tb_gpr_scoreboard;

    logic       clk = 1'b0;
    logic       srst_i;
    logic       upd_write_i;
    logic [4:0] upd_rdindex_i;
    logic [7:0] upd_itag_i;
    logic       rel_valid_i;
    logic [4:0] rel_rdindex_i;
    logic [7:0] rel_itag_i;
    logic       flush_i;
    logic [4:0] rs1_index_i;
    logic [4:0] rs2_index_i;
    logic [4:0] rd_index_i;
    logic       rs1_busy_o;
    logic       rs2_busy_o;
    logic       rd_busy_o;
    logic [7:0] rs1_itag_o;
    logic [7:0] rs2_itag_o;
    logic [5:0] busy_cnt_o;
    logic       idle_o;

    always #5 clk = ~clk;

    gpr_scoreboard dut (
        .clk_i         (clk),
        .srst_i        (srst_i),
        .upd_write_i   (upd_write_i),
        .upd_rdindex_i (upd_rdindex_i),
        .upd_itag_i    (upd_itag_i),
        .rel_valid_i   (rel_valid_i),
        .rel_rdindex_i (rel_rdindex_i),
        .rel_itag_i    (rel_itag_i),
        .flush_i       (flush_i),
        .rs1_index_i   (rs1_index_i),
        .rs2_index_i   (rs2_index_i),
        .rd_index_i    (rd_index_i),
        .rs1_busy_o    (rs1_busy_o),
        .rs2_busy_o    (rs2_busy_o),
        .rd_busy_o     (rd_busy_o),
        .rs1_itag_o    (rs1_itag_o),
        .rs2_itag_o    (rs2_itag_o),
        .busy_cnt_o    (busy_cnt_o),
        .idle_o        (idle_o)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: set of pending registers and their producer tags.
    bit       m_busy [32];
    bit [7:0] m_tag  [32];

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input bit tags);
        for (int i = 0; i < 32; i++) begin
            m_busy[i] = 1'b0;
            if (tags) m_tag[i] = 8'h00;
        end
    endtask

    task automatic step(input bit s, input bit uw, input bit [4:0] ui,
                        input bit [7:0] ut, input bit rv, input bit [4:0] ri,
                        input bit [7:0] rt, input bit fl, input bit [4:0] a,
                        input bit [4:0] b, input bit [4:0] c);
        bit       rel_match;
        bit       byp;
        bit       e1;
        bit       e2;
        bit       e3;
        int       cnt;
        @(negedge clk);
        srst_i        = s;
        upd_write_i   = uw;
        upd_rdindex_i = ui;
        upd_itag_i    = ut;
        rel_valid_i   = rv;
        rel_rdindex_i = ri;
        rel_itag_i    = rt;
        flush_i       = fl;
        rs1_index_i   = a;
        rs2_index_i   = b;
        rd_index_i    = c;
        #1;
        rel_match = rv && m_busy[ri] && (m_tag[ri] == rt);
`ifdef PRV664_SCOREBOARD_BYPASS_EN
        byp = rel_match && !(uw && ui != 0 && ui == ri) && !fl && !s;
`else
        byp = 1'b0;
`endif
        e1 = m_busy[a] && !(byp && a == ri);
        e2 = m_busy[b] && !(byp && b == ri);
        e3 = m_busy[c] && !(byp && c == ri);
        cnt = 0;
        for (int i = 0; i < 32; i++) cnt += int'(m_busy[i]);
        chk("rs1_busy", 8'(rs1_busy_o), 8'(e1));
        chk("rs2_busy", 8'(rs2_busy_o), 8'(e2));
        chk("rd_busy", 8'(rd_busy_o), 8'(e3));
        chk("rs1_itag", rs1_itag_o, e1 ? m_tag[a] : 8'h00);
        chk("rs2_itag", rs2_itag_o, e2 ? m_tag[b] : 8'h00);
        chk("busy_cnt", 8'(busy_cnt_o), 8'(cnt));
        chk("idle", 8'(idle_o), 8'(cnt == 0));
        @(posedge clk);
        if (s) begin
            model_clear(1'b1);
        end else if (fl) begin
            model_clear(1'b0);
        end else begin
            if (rel_match) m_busy[ri] = 1'b0;
            if (uw && ui != 0) begin
                m_busy[ui] = 1'b1;
                m_tag[ui]  = ut;
            end
        end
    endtask

    task automatic look(input bit [4:0] a, input bit [4:0] b,
                        input bit [4:0] c);
        step(0, 0, 0, 0, 0, 0, 0, 0, a, b, c);
    endtask

    initial begin
        bit [4:0] ui;
        bit [4:0] ri;
        bit [7:0] rt;
        bit [4:0] a;
        bit [4:0] b;
        srst_i = 1'b1;
        upd_write_i = 0; upd_rdindex_i = 0; upd_itag_i = 0;
        rel_valid_i = 0; rel_rdindex_i = 0; rel_itag_i = 0;
        flush_i = 0; rs1_index_i = 0; rs2_index_i = 0; rd_index_i = 0;
        repeat (2) @(posedge clk);
        model_clear(1'b1);

        look(0, 5, 31);
        step(0, 1, 5, 8'h1A, 0, 0, 0, 0, 5, 5, 5);
        look(5, 0, 5);
        step(0, 0, 0, 0, 1, 5, 8'h1B, 0, 5, 5, 5);
        look(5, 5, 5);
        step(0, 0, 0, 0, 1, 5, 8'h1A, 0, 5, 5, 5);
        look(5, 5, 5);

        step(0, 1, 7, 8'h03, 0, 0, 0, 0, 7, 7, 7);
        step(0, 1, 7, 8'h04, 1, 7, 8'h03, 0, 7, 7, 7);
        look(7, 7, 7);
        step(0, 1, 2, 8'h22, 1, 7, 8'h04, 0, 2, 7, 2);
        look(2, 7, 2);
        step(0, 0, 0, 0, 1, 2, 8'h22, 0, 2, 2, 2);

        step(0, 1, 0, 8'h55, 0, 0, 0, 0, 0, 0, 0);
        look(0, 0, 0);

        for (int i = 1; i < 32; i++)
            step(0, 1, 5'(i), 8'(i + 32), 0, 0, 0, 0, 5'(i), 3, 31);
        look(3, 17, 31);
        step(0, 1, 3, 8'h77, 1, 4, 8'd36, 1, 3, 4, 3);
        look(3, 1, 31);

        step(0, 1, 9, 8'h10, 0, 0, 0, 0, 9, 9, 9);
        step(0, 0, 0, 0, 1, 9, 8'h10, 0, 9, 9, 9);
        look(9, 9, 9);

        step(0, 1, 4, 8'h44, 0, 0, 0, 0, 4, 4, 4);
        step(1, 1, 6, 8'h66, 1, 4, 8'h44, 0, 4, 6, 6);
        look(4, 6, 4);

        for (int n = 0; n < 500; n++) begin
            ui = 5'($urandom_range(0, 31));
            ri = 5'($urandom_range(0, 31));
            rt = ($urandom_range(0, 3) != 0) ? m_tag[ri] : 8'($urandom);
            a  = ($urandom_range(0, 1) != 0) ? ri : 5'($urandom);
            b  = ($urandom_range(0, 1) != 0) ? ui : ri;
            step($urandom_range(0, 149) == 0,
                 $urandom_range(0, 1) != 0, ui, 8'($urandom),
                 $urandom_range(0, 4) < 3, ri, rt,
                 $urandom_range(0, 39) == 0,
                 a, b, 5'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
